// File: rtl/register_file_stack_if.sv
// Register file / stack access bundle: select, enables and data.
// master drives rd, wn, stack_en, push_en, pop_en, reg_id, write_data; slave drives read_data.
interface register_file_stack_if #(
    parameter int DATA_W = 16,
    parameter int ID_W   = 4
);
    logic              rd;
    logic              wn;
    logic              stack_en;
    logic              push_en;
    logic              pop_en;
    logic [ID_W-1:0]   reg_id;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    modport master (
        output rd, wn, stack_en, push_en, pop_en, reg_id, write_data,
        input  read_data
    );

    modport slave (
        input  rd, wn, stack_en, push_en, pop_en, reg_id, write_data,
        output read_data
    );
endinterface

// File: rtl/register_file_stack.sv
// Register file with attached LIFO stack; one op on reg_id per clock.
// Ports: clk, reset (async active-low), bus (register_file_stack_if.slave).
// Option REGFILE_ZERO_REG_EN: register 0 is hardwired to zero.
module register_file_stack #(
    parameter int DATA_W      = 16,
    parameter int NUM_REGS    = 16,
    parameter int STACK_DEPTH = 16
) (
    input logic                   clk,
    input logic                   reset,
    register_file_stack_if.slave  bus
);
    localparam int ID_W  = $clog2(NUM_REGS);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [DATA_W-1:0] r_regs  [NUM_REGS];
    logic [DATA_W-1:0] r_stack [STACK_DEPTH];
    logic [SP_W-1:0]   r_sp;
    logic [DATA_W-1:0] r_read_data;

    logic [DATA_W-1:0] w_src;
    logic              w_push;
    logic              w_pop;
    logic [SP_W-1:0]   w_sp_m1;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_wr_ok;

    // Push/pop qualifiers are masked by stack_en first so that
    // unknown push_en/pop_en outside stack mode cannot leak in.
    assign w_push = bus.stack_en && bus.push_en && !bus.pop_en
                    && (r_sp < SP_W'(STACK_DEPTH));
    assign w_pop  = bus.stack_en && bus.pop_en && !bus.push_en
                    && (r_sp != '0);
    assign w_sp_m1 = r_sp - 1'b1;

`ifdef REGFILE_ZERO_REG_EN
    assign w_src   = (bus.reg_id == '0) ? '0 : r_regs[bus.reg_id];
    assign w_wr_ok = (bus.reg_id != '0);
`else
    assign w_src   = r_regs[bus.reg_id];
    assign w_wr_ok = 1'b1;
`endif

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_data = bus.write_data;
        if (w_pop) begin
            w_wr_en   = 1'b1;
            w_wr_data = r_stack[w_sp_m1[IDX_W-1:0]];
        end else if (!bus.stack_en && bus.wn) begin
            w_wr_en   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
            r_sp        <= '0;
            r_read_data <= '0;
        end else begin
            if (bus.rd) r_read_data <= w_src;
            // A pop into a hardwired register still consumes the entry.
            if (w_wr_en && w_wr_ok) r_regs[bus.reg_id] <= w_wr_data;
            if (w_push) begin
                r_stack[r_sp[IDX_W-1:0]] <= w_src;
                r_sp <= r_sp + 1'b1;
            end else if (w_pop) begin
                r_sp <= w_sp_m1;
            end
        end
    end

    assign bus.read_data = r_read_data;

    logic [ID_W-1:0] w_unused_id;
    assign w_unused_id = bus.reg_id;
endmodule

// File: tb/tb_register_file_stack.sv
// Self-checking bench for register_file_stack: directed steps plus
// random traffic against a queue-based reference model.
module tb_register_file_stack;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    register_file_stack_if #(.DATA_W(16), .ID_W(4)) bus ();

    register_file_stack #(
        .DATA_W(16), .NUM_REGS(16), .STACK_DEPTH(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_regs [16];
    logic [15:0] m_stk [$];
    logic [15:0] m_rd;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_stk.delete();
        m_rd = '0;
    endtask

    function automatic logic [15:0] m_get(int id);
        return (ZERO && id == 0) ? 16'h0 : m_regs[id];
    endfunction

    task automatic m_put(int id, logic [15:0] v);
        if (!(ZERO && id == 0)) m_regs[id] = v;
    endtask

    // One clock: apply the rules to the model, then compare.
    task automatic cycle(string tag);
        int          id;
        logic [15:0] old;
        @(posedge clk);
        id  = int'(bus.reg_id);
        old = m_get(id);
        if (bus.rd) m_rd = old;
        if (!bus.stack_en) begin
            if (bus.wn) m_put(id, bus.write_data);
        end else if (bus.push_en && !bus.pop_en) begin
            if (m_stk.size() < 16) m_stk.push_back(old);
        end else if (bus.pop_en && !bus.push_en) begin
            if (m_stk.size() > 0) m_put(id, m_stk.pop_back());
        end
        #1;
        chk({tag, ".rdata"}, 32'(bus.read_data), 32'(m_rd));
        chk({tag, ".sp"}, 32'(dut.r_sp), 32'(m_stk.size()));
    endtask

    task automatic drv(bit rd, bit wn, bit se, bit pu, bit po,
                       int id, logic [15:0] wd);
        bus.rd         = rd;
        bus.wn         = wn;
        bus.stack_en   = se;
        bus.push_en    = pu;
        bus.pop_en     = po;
        bus.reg_id     = 4'(id);
        bus.write_data = wd;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 16'h0);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        m_reset();
        #12;
        chk("reset.rdata", 32'(bus.read_data), 32'h0);
        chk("reset.sp", 32'(dut.r_sp), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drv(1, 0, 0, 0, 0, i, 16'h0);
            cycle("zero_read");
        end

        drv(0, 1, 0, 0, 0, 2, 16'd15);
        cycle("wr_r2");
        drv(1, 0, 0, 0, 0, 2, 16'h0);
        cycle("rd_r2");
        chk("rd_r2.lit", 32'(bus.read_data), 32'd15);

        drv(1, 1, 0, 0, 0, 4, 16'h0BEE);
        cycle("rw_same_old");
        drv(1, 0, 0, 0, 0, 4, 16'h0);
        cycle("rw_same_new");
        chk("rw_same.lit", 32'(bus.read_data), 32'h0BEE);

        drv(0, 0, 1, 1, 0, 2, 16'h0);
        cycle("push1");
        cycle("push2");
        chk("push2.sp", 32'(dut.r_sp), 32'd2);
        drv(0, 1, 0, 0, 0, 2, 16'd7);
        cycle("wr_r2_7");
        drv(0, 0, 1, 0, 1, 2, 16'h0);
        cycle("pop1");
        drv(1, 0, 0, 0, 0, 2, 16'h0);
        cycle("pop1_rd");
        chk("pop1.lit", 32'(bus.read_data), 32'd15);
        drv(0, 0, 1, 0, 1, 9, 16'h0);
        cycle("drain");

        drv(0, 1, 0, 0, 0, 5, 16'h00AA);
        cycle("wr_r5");
        drv(0, 0, 1, 0, 1, 5, 16'h0);
        cycle("pop_empty");
        drv(1, 0, 0, 0, 0, 5, 16'h0);
        cycle("pop_empty_rd");
        chk("pop_empty.lit", 32'(bus.read_data), 32'h00AA);

        for (int i = 0; i < 17; i++) begin
            drv(0, 0, 1, 1, 0, i % 16, 16'h0);
            cycle("push_fill");
        end
        chk("full.sp", 32'(dut.r_sp), 32'd16);
        drv(0, 0, 1, 0, 1, 6, 16'h0);
        cycle("pop_top");
        drv(1, 0, 0, 0, 0, 6, 16'h0);
        cycle("pop_top_rd");

        drv(0, 1, 1, 0, 0, 3, 16'h1234);
        cycle("se_blocks_wn");
        drv(1, 0, 0, 0, 0, 3, 16'h0);
        cycle("se_blocks_wn_rd");
        drv(0, 0, 1, 1, 1, 3, 16'h0);
        cycle("push_pop_both");
        drv(0, 0, 0, 1, 1, 3, 16'h0);
        cycle("no_se_ignore");

`ifdef REGFILE_ZERO_REG_EN
        drv(0, 1, 0, 0, 0, 0, 16'hFFFF);
        cycle("wr_r0");
        drv(1, 0, 0, 0, 0, 0, 16'h0);
        cycle("rd_r0");
        chk("rd_r0.lit", 32'(bus.read_data), 32'h0);
`endif

        for (int n = 0; n < 400; n++) begin
            logic [31:0] r;
            r = $urandom;
            drv(r[0], r[1], r[2] & r[3], r[4], r[5],
                int'(r[9:6]), r[25:10]);
            cycle("rand");
        end

        drv(1, 0, 1, 1, 0, 5, 16'h0);
        cycle("burst1");
        cycle("burst2");
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        #1;
        chk("midrst.rdata", 32'(bus.read_data), 32'h0);
        chk("midrst.sp", 32'(dut.r_sp), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        drv(0, 0, 1, 0, 1, 5, 16'h0);
        cycle("pop_after_rst");
        drv(1, 0, 0, 0, 0, 5, 16'h0);
        cycle("pop_after_rst_rd");
        chk("pop_after_rst.lit", 32'(bus.read_data), 32'h0);

        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
